filter_lookup_arbiter: RTL and testbench

//  Shares one filter rule engine among NUM_REQ header-parser requesters, e.g. one parser per 10G port.

---
 rtl/filter_lookup_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_filter_lookup_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_lookup_arbiter.sv
// Round-robin arbiter sharing one filter rule engine among NUM_REQ parsers.
// Ports: req_* requester side, eng_* engine side, grant/busy/lookup_cnt status.
// Optional watchdog on the WAIT state: define FILTER_ARB_TIMEOUT_EN.
module filter_lookup_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TUPLE_W        = 104,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       axi_aclk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*TUPLE_W-1:0] req_tuple,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       req_send,
  output logic                       req_timeout,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic [31:0]                lookup_cnt,
  output logic                       eng_hdr_rd,
  output logic                       eng_hdr_clear,
  output logic [31:0]                eng_src_ip,
  output logic [31:0]                eng_dst_ip,
  output logic [15:0]                eng_src_port,
  output logic [15:0]                eng_dst_port,
  output logic [7:0]                 eng_proto,
  input  logic                       eng_send_rd,
  input  logic                       eng_send
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("filter_lookup_arbiter: NUM_REQ and TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CLEAR
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 send_q, send_d;
  logic                 tmo_q, tmo_d;
  logic                 rd_q, rd_d;
  logic                 clr_q, clr_d;
  logic                 busy_q, busy_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [TUPLE_W-1:0]   tup_q, tup_d;

  logic                 found;
  logic [PW-1:0]        win;
  int                   idx;
  logic                 timed_out;

  // First requester after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

`ifdef FILTER_ARB_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == S_ISSUE) begin
      wdog_d = '0;
    end else if (state_q == S_WAIT) begin
      wdog_d = wdog_q + 16'd1;
    end
  end

  // Fires on the last allowed WAIT cycle; a verdict in that cycle wins.
  assign timed_out = (state_q == S_WAIT) && !eng_send_rd &&
                     (wdog_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge axi_aclk) begin
    if (reset) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ack_d   = '0;
    send_d  = send_q;
    tmo_d   = tmo_q;
    rd_d    = rd_q;
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    tup_d   = tup_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_ISSUE;
          ptr_d   = win;
          grant_d = NUM_REQ'(1) << win;
          tup_d   = req_tuple[int'(win)*TUPLE_W +: TUPLE_W];
          rd_d    = 1'b1;
          clr_d   = 1'b0;
        end
      end
      // A verdict seen here may be left over from the previous lookup.
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_send_rd || timed_out) begin
          state_d = S_CLEAR;
          ack_d   = grant_q;
          send_d  = eng_send_rd & eng_send;
          tmo_d   = timed_out;
          cnt_d   = cnt_q + 32'd1;
          rd_d    = 1'b0;
          clr_d   = 1'b1;
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NUM_REQ - 1);
      grant_q <= '0;
      ack_q   <= '0;
      send_q  <= 1'b0;
      tmo_q   <= 1'b0;
      rd_q    <= 1'b0;
      clr_q   <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      tup_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      send_q  <= send_d;
      tmo_q   <= tmo_d;
      rd_q    <= rd_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      tup_q   <= tup_d;
    end
  end

  assign req_ack       = ack_q;
  assign req_send      = send_q;
  assign req_timeout   = tmo_q;
  assign grant         = grant_q;
  assign busy          = busy_q;
  assign lookup_cnt    = cnt_q;
  assign eng_hdr_rd    = rd_q;
  assign eng_hdr_clear = clr_q;
  assign eng_src_ip    = tup_q[103:72];
  assign eng_dst_ip    = tup_q[71:40];
  assign eng_src_port  = tup_q[39:24];
  assign eng_dst_port  = tup_q[23:8];
  assign eng_proto     = tup_q[7:0];

endmodule

// File: tb/tb_filter_lookup_arbiter.sv
// Self-checking bench for filter_lookup_arbiter.
// Directed scenarios plus random traffic against a lookup-level model.
module tb_filter_lookup_arbiter;

  localparam int N   = 4;
  localparam int TW  = 104;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tuple;
  logic [N-1:0]    req_ack;
  logic            req_send;
  logic            req_timeout;
  logic [N-1:0]    grant;
  logic            busy;
  logic [31:0]     lookup_cnt;
  logic            eng_hdr_rd;
  logic            eng_hdr_clear;
  logic [31:0]     eng_src_ip;
  logic [31:0]     eng_dst_ip;
  logic [15:0]     eng_src_port;
  logic [15:0]     eng_dst_port;
  logic [7:0]      eng_proto;
  logic            eng_send_rd;
  logic            eng_send;

  filter_lookup_arbiter #(
    .NUM_REQ(N),
    .TUPLE_W(TW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .axi_aclk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_tuple(req_tuple),
    .req_ack(req_ack),
    .req_send(req_send),
    .req_timeout(req_timeout),
    .grant(grant),
    .busy(busy),
    .lookup_cnt(lookup_cnt),
    .eng_hdr_rd(eng_hdr_rd),
    .eng_hdr_clear(eng_hdr_clear),
    .eng_src_ip(eng_src_ip),
    .eng_dst_ip(eng_dst_ip),
    .eng_src_port(eng_src_port),
    .eng_dst_port(eng_dst_port),
    .eng_proto(eng_proto),
    .eng_send_rd(eng_send_rd),
    .eng_send(eng_send)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TW-1:0] rnd_tuple();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[TW-1:0];
  endfunction

  // Lookup-level model: who owns the engine, how long since grant,
  // and whether the verdict has been returned.
  int           m_owner = -1;
  int           m_age   = 0;
  int           m_ptr   = N - 1;
  int           m_idx;
  bit           m_done  = 1'b0;
  bit           m_hit;
  logic [31:0]  m_cnt   = '0;
  logic [N-1:0] m_ack   = '0;
  bit           m_send  = 1'b0;
  bit           m_tmo   = 1'b0;
  logic [TW-1:0] m_tup  = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_owner = -1;
      m_done  = 1'b0;
      m_ptr   = N - 1;
      m_cnt   = '0;
      m_ack   = '0;
      m_send  = 1'b0;
      m_tmo   = 1'b0;
      m_tup   = '0;
    end else begin
      m_ack = '0;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          m_idx = (m_ptr + k) % N;
          if (m_owner < 0 && req_valid[m_idx]) begin
            m_owner = m_idx;
            m_ptr   = m_idx;
            m_tup   = req_tuple[m_idx*TW +: TW];
            m_age   = 1;
            m_done  = 1'b0;
          end
        end
      end else if (m_done) begin
        m_owner = -1;
        m_done  = 1'b0;
      end else begin
`ifdef FILTER_ARB_TIMEOUT_EN
        m_hit = (m_age >= 2) && (m_age - 1 >= TMO);
`else
        m_hit = 1'b0;
`endif
        if (m_age >= 2 && (eng_send_rd || m_hit)) begin
          m_done = 1'b1;
          m_ack  = N'(1) << m_owner;
          m_send = eng_send_rd ? eng_send : 1'b0;
          m_tmo  = !eng_send_rd;
          m_cnt  = m_cnt + 32'd1;
        end else begin
          m_age++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0] eg;
      logic         erd;
      eg  = (m_owner >= 0) ? N'(1) << m_owner : '0;
      erd = (m_owner >= 0) && !m_done;
      check("grant", grant, eg);
      check("busy", busy, m_owner >= 0);
      check("req_ack", req_ack, m_ack);
      check("eng_hdr_rd", eng_hdr_rd, erd);
      check("eng_hdr_clear", eng_hdr_clear, !erd);
      check("lookup_cnt", lookup_cnt, m_cnt);
      check("eng_tuple", {eng_src_ip, eng_dst_ip, eng_src_port,
                          eng_dst_port, eng_proto}, m_tup);
      if (|m_ack) begin
        check("req_send", req_send, m_send);
        check("req_timeout", req_timeout, m_tmo);
      end
    end
  end

  int           gq[$];
  logic [N-1:0] last_g;
  int           acks;
  int           ack_cyc;
  bit           ack_seen;
  logic [TW-1:0] t2;

  initial begin
    reset       = 1'b1;
    req_valid   = N'($urandom);
    req_tuple   = {rnd_tuple(), rnd_tuple(), rnd_tuple(), rnd_tuple()};
    eng_send_rd = 1'b1;
    eng_send    = 1'b1;

    // T1 reset with random inputs
    tick();
    chk_en = 1'b1;
    req_valid = N'($urandom);
    tick();
    @(negedge clk);
    check("t1_grant", grant, 4'b0000);
    check("t1_clear", eng_hdr_clear, 1'b1);
    check("t1_cnt", lookup_cnt, 32'd0);
    check("t1_rd", eng_hdr_rd, 1'b0);
    reset = 1'b0;
    req_valid = '0;
    eng_send_rd = 1'b0;
    tick();

    // T2 single request
    t2 = {32'hAAAAAAAA, 32'hBBBBBBBB, 16'h0050, 16'h1F90, 8'h06};
    req_tuple[2*TW +: TW] = t2;
    req_valid = 4'b0100;
    tick();
    @(negedge clk);
    check("t2_grant", grant, 4'b0100);
    check("t2_src_ip", eng_src_ip, 32'hAAAAAAAA);
    check("t2_proto", eng_proto, 8'h06);
    tick();
    eng_send_rd = 1'b1;
    eng_send    = 1'b1;
    tick();
    eng_send_rd = 1'b0;
    req_valid   = '0;
    @(negedge clk);
    check("t2_ack", req_ack, 4'b0100);
    check("t2_send", req_send, 1'b1);
    check("t2_cnt", lookup_cnt, 32'd1);
    tick();
    tick();

    // T3/T4 round robin with an always-ready engine
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b1111;
    eng_send_rd = 1'b1;
    last_g = '0;
    acks = 0;
    for (int c = 1; c <= 20; c++) begin
      eng_send = 1'($urandom);
      tick();
      @(negedge clk);
      if (grant != 0 && grant != last_g) begin
        for (int i = 0; i < N; i++) if (grant[i]) gq.push_back(i);
      end
      last_g = grant;
      if (|req_ack) acks++;
    end
    check("t3_ngrant", gq.size(), 5);
    if (gq.size() >= 5) begin
      check("t3_g0", gq[0], 0);
      check("t3_g1", gq[1], 1);
      check("t3_g2", gq[2], 2);
      check("t3_g3", gq[3], 3);
      check("t3_g4", gq[4], 0);
    end
    check("t4_acks", acks, 5);
    req_valid = '0;
    eng_send_rd = 1'b0;
    tick();
    tick();
    tick();

    // T5 reset mid-WAIT of requester 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b0010;
    tick();
    tick();
    tick();
    reset = 1'b1;
    req_valid = 4'b0011;
    tick();
    @(negedge clk);
    check("t5_grant", grant, 4'b0000);
    check("t5_ack", req_ack, 4'b0000);
    check("t5_cnt", lookup_cnt, 32'd0);
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("t5_regrant", grant, 4'b0001);
    eng_send_rd = 1'b1;
    tick();
    tick();
    tick();
    req_valid = '0;
    eng_send_rd = 1'b0;
    tick();
    tick();

    // T6 engine never answers
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b0001;
    ack_cyc = -1;
`ifdef FILTER_ARB_TIMEOUT_EN
    for (int c = 1; c <= 12; c++) begin
      tick();
      @(negedge clk);
      if (|req_ack && ack_cyc < 0) begin
        ack_cyc = c;
        check("t6_tmo", req_timeout, 1'b1);
        check("t6_send", req_send, 1'b0);
      end
    end
    check("t6_ack_cyc", ack_cyc, 10);
`else
    ack_seen = 1'b0;
    for (int c = 1; c <= 110; c++) begin
      tick();
      @(negedge clk);
      if (|req_ack) ack_seen = 1'b1;
    end
    check("t6_no_ack", ack_seen, 1'b0);
    check("t6_held", grant, 4'b0001);
`endif
    req_valid = '0;
    eng_send_rd = 1'b1;
    tick();
    tick();
    tick();
    eng_send_rd = 1'b0;

    // Random traffic; requesters hold valid until acked
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(3) == 0) begin
          req_valid[i] = 1'b1;
          req_tuple[i*TW +: TW] = rnd_tuple();
        end
      end
      eng_send_rd = ($urandom_range(2) == 0);
      eng_send    = 1'($urandom);
      reset       = ($urandom_range(499) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
